// File: rtl/mpi_pkg.sv
// Shared types and helpers for the MPI virtual-channel link arbiter.
package mpi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } mpi_state_e;

  function automatic int unsigned mpi_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mpi_rr_arbiter.sv
// Combinational wrap-around priority search: first requester at or above ptr,
// wrapping modulo N. Returns a one-hot grant, its index, and whether any request exists.
module mpi_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             pos;
  int             sum;

  // Rotating the doubled request vector puts ptr at bit 0, so the lowest set bit wins.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    pos = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) pos = k;
    end
    sum = int'(ptr) + pos;
    if (sum >= N) sum = sum - N;
    any = |rot;
    idx = any ? IDX_W'(sum) : '0;
    gnt = any ? (N'(1) << sum) : '0;
  end

endmodule

// File: rtl/mpi_vc_arbiter.sv
// Packet-locked round-robin arbiter muxing N virtual-channel flit streams onto one
// registered NoC link; a channel owns the link from its first flit to its last.
module mpi_vc_arbiter
  import mpi_pkg::*;
#(
  parameter int NOC_FLIT_WIDTH = 32,
  parameter int N              = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N*NOC_FLIT_WIDTH-1:0] in_flit,
  input  logic [N-1:0]                in_last,
  input  logic [N-1:0]                in_valid,
  output logic [N-1:0]                in_ready,
  output logic [NOC_FLIT_WIDTH-1:0]   out_flit,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  mpi_state_e                state_q, state_d;
  logic [IDX_W-1:0]          grant_q, grant_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [NOC_FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
  logic                      out_last_q, out_last_d;
  logic                      out_valid_q, out_valid_d;

  logic [N-1:0]              arb_gnt;
  logic [IDX_W-1:0]          arb_idx;
  logic                      arb_any;

  logic                      accept;
  logic [IDX_W-1:0]          sel_idx;
  logic [N-1:0]              sel_oh;
  logic [NOC_FLIT_WIDTH-1:0] sel_flit;
  logic                      sel_last;
  logic                      xfer;

  mpi_rr_arbiter #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rr (
    .req (in_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // A locked owner keeps in_ready even while its valid is low, so no other channel sneaks in.
  always_comb begin
    accept   = !out_valid_q || out_ready;
    sel_idx  = (state_q == LOCKED) ? grant_q : arb_idx;
    sel_oh   = (state_q == LOCKED) ? (N'(1) << grant_q) : arb_gnt;
    sel_flit = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (IDX_W'(i) == sel_idx) begin
        sel_flit = in_flit[i*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH];
        sel_last = in_last[i];
      end
    end
    in_ready = (!rst && accept && (state_q == LOCKED || arb_any)) ? sel_oh : '0;
    xfer     = |(in_ready & in_valid);
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    out_flit_d  = out_flit_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_flit_d = sel_flit;
        out_last_d = sel_last;
      end
    end
    if (xfer) begin
      if (sel_last) begin
        state_d = IDLE;
        ptr_d   = IDX_W'(mpi_wrap_inc(32'(sel_idx), N));
      end else if (state_q == IDLE) begin
        state_d = LOCKED;
        grant_d = sel_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      out_flit_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      out_flit_q  <= out_flit_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_flit  = out_flit_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule
